// File: rtl/pipeline_pkg.sv
// pipeline_pkg: default pipeline geometry and the reference arithmetic of the pipeline
package pipeline_pkg;
  localparam int W_DEFAULT = 3;
  localparam int LATENCY_DEFAULT = 3;
  function automatic logic [31:0] calc_res(input logic [31:0] a, b, c, d, e);
    return a * b + c - d * e;
  endfunction
endpackage

// File: rtl/pipeline_issuer_fifo.sv
// result_fifo: synchronous FIFO with wrap-bit pointers; push and pop may coincide even when full
module result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t wp, rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign empty = wp == rp;
  assign count = wp - rp;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + ptr_t'(push);
      rp <= rp + ptr_t'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/pipeline_issuer.sv
// pipeline_issuer: issues operand tuples into the arithmetic pipeline under credit control,
// captures and checks the results, and hands them downstream through a small FIFO.
module pipeline_issuer
  import pipeline_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT,
  parameter int RES_DEPTH = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  input  logic [W-1:0] in_e,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [W-1:0] e,
  output logic         load,
  input  logic [W-1:0] res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_ok,
  output logic [7:0]   err_count
);
  localparam int CW = $clog2(RES_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;
  cnt_t credits, count;
  logic [W-1:0] exp_q;
  logic [LATENCY-1:0] vld_sr;
  logic [LATENCY-1:0][W-1:0] exp_sr;
  logic accept, pop, push, match, full, empty;
  logic [W:0] head;
  assign in_ready = !clear && credits != '0;
  assign accept = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign push = vld_sr[LATENCY-1];
  assign match = res == exp_sr[LATENCY-1];
  assign out_valid = !empty;
  assign {out_res, out_ok} = empty ? '0 : head;
  // exp_q travels with the issued operands so exp_sr lines up with load in vld_sr
  always_ff @(posedge clk)
    if (clear) begin
      {a, b, c, d, e} <= '0;
      load <= 1'b0;
      exp_q <= '0;
      credits <= cnt_t'(RES_DEPTH);
      vld_sr <= '0;
      exp_sr <= '0;
      err_count <= '0;
    end else begin
      load <= accept;
      if (accept) begin
        {a, b, c, d, e} <= {in_a, in_b, in_c, in_d, in_e};
        exp_q <= W'(calc_res(32'(in_a), 32'(in_b), 32'(in_c), 32'(in_d), 32'(in_e)));
      end
      credits <= credits - cnt_t'(accept) + cnt_t'(pop);
      vld_sr <= {vld_sr[LATENCY-2:0], load};
      exp_sr <= {exp_sr[LATENCY-2:0], exp_q};
      if (push && !match && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  result_fifo #(.WIDTH(W + 1), .DEPTH(RES_DEPTH)) u_fifo (
    .clk(clk),
    .clear(clear),
    .push(push),
    .pop(pop),
    .din({res, match}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk)
    if (!clear) begin
      assert (!(push && full && !pop));
      assert (credits <= cnt_t'(RES_DEPTH));
      assert (32'(credits) + 32'(count) <= RES_DEPTH);
    end else
      assert (!accept);
endmodule

// File: tb/tb_pipeline_issuer.sv
// tb_pipeline_issuer: drives pipeline_issuer against a behavioural pipeline and checks results
// with a queue-based scoreboard of accepted tuples.
`timescale 1ns/1ps
module tb_pipeline_issuer;
  localparam int W = 3;
  localparam int MOD = 1 << W;
  logic clk, clear, in_valid, in_ready, load, out_valid, out_ready, out_ok, res_mask;
  logic [W-1:0] in_a, in_b, in_c, in_d, in_e, a, b, c, d, e, res, out_res;
  logic [W-1:0] p0, p1, p2;
  logic [7:0] err_count;
  int checks = 0, errors = 0, errs_exp = 0;
  int q_res[$];
  bit q_ok[$];

  pipeline_issuer #(.W(W), .LATENCY(3), .RES_DEPTH(4)) dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
    .a(a), .b(b), .c(c), .d(d), .e(e), .load(load), .res(res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_ok(out_ok), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  // three-stage arithmetic pipeline; res_mask corrupts the result of whatever it samples
  always_ff @(posedge clk)
    if (clear) {p0, p1, p2} <= '0;
    else begin
      p0 <= W'(a * b + c - d * e) ^ {2'b00, res_mask};
      p1 <= p0;
      p2 <= p1;
    end
  assign res = p2;

  function automatic int ref_res(int va, int vb, int vc, int vd, int ve);
    int v = va * vb + vc - vd * ve;
    return ((v % MOD) + MOD) % MOD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic put(input int va, vb, vc, vd, ve);
    {in_a, in_b, in_c, in_d, in_e} = {W'(va), W'(vb), W'(vc), W'(vd), W'(ve)};
  endtask

  task automatic put_rand();
    put($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
        $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  // one clock: score the pop/accept seen before the edge, then check credit-driven in_ready
  task automatic tick();
    bit acc, pp;
    acc = !clear && in_valid && in_ready;
    pp = !clear && out_valid && out_ready;
    if (pp) begin
      if (q_res.size() == 0) chk("stale_pop", out_valid, 0);
      else begin
        chk("out_res", out_res, q_res.pop_front());
        chk("out_ok", out_ok, q_ok.pop_front());
      end
    end
    if (acc) begin
      q_res.push_back(ref_res(in_a, in_b, in_c, in_d, in_e) ^ int'(res_mask));
      q_ok.push_back(!res_mask);
      if (res_mask && errs_exp < 255) errs_exp++;
    end
    if (clear) begin
      q_res.delete();
      q_ok.delete();
      errs_exp = 0;
    end
    @(posedge clk);
    #1;
    chk("in_ready", in_ready, !clear && q_res.size() < 4);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q_res.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_left", q_res.size(), 0);
    chk("drain_out_valid", out_valid, 0);
    chk("err_count", err_count, errs_exp);
  endtask

  initial begin
    int lat, acc, issued, n;
    int exp_tab[3] = '{1, 5, 0};
    int tup[3][5] = '{'{1, 0, 3, 1, 2}, '{7, 1, 0, 2, 1}, '{2, 2, 2, 6, 1}};
    clear = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    res_mask = 1'b0;
    put(0, 0, 0, 0, 0);
    // reset
    tick();
    tick();
    chk("rst_ops", {a, b, c, d, e}, 0);
    chk("rst_load", load, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_ok", out_ok, 0);
    chk("rst_err", err_count, 0);
    clear = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    // single tuples, each waited for
    for (int i = 0; i < 3; i++) begin
      put(tup[i][0], tup[i][1], tup[i][2], tup[i][3], tup[i][4]);
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("single_load", load, 1);
      chk("single_a", a, tup[i][0]);
      chk("single_e", e, tup[i][4]);
      lat = 0;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      // accept edge plus LATENCY+1 further edges
      chk("single_latency", lat, 4);
      chk("single_res", out_res, exp_tab[i]);
      chk("single_ok", out_ok, 1);
      drain();
    end
    // streaming
    for (int i = 0; i < 3; i++) begin
      put(tup[i][0], tup[i][1], tup[i][2], tup[i][3], tup[i][4]);
      in_valid = 1'b1;
      tick();
      chk("stream_load", load, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_load_low", load, 0);
    chk("stream_q", q_res.size(), 3);
    drain();
    // backpressure
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      put_rand();
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_pop_ready", in_ready, 1);
    drain();
    // single mismatch
    res_mask = 1'b1;
    put_rand();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
    res_mask = 1'b0;
    chk("mismatch_one", err_count, 1);
    // saturation
    res_mask = 1'b1;
    issued = 0;
    out_ready = 1'b1;
    for (n = 0; issued < 300 && n < 3000; n++) begin
      put_rand();
      in_valid = 1'b1;
      if (in_ready) issued++;
      tick();
    end
    chk("sat_issued", issued, 300);
    drain();
    res_mask = 1'b0;
    chk("sat_err", err_count, 255);
    // mid-flight reset: two results queued, two in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      put_rand();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mf_queued", out_valid, 1);
    for (int i = 0; i < 2; i++) begin
      put_rand();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("mf_out_valid", out_valid, 0);
    chk("mf_credits", dut.credits, 4);
    chk("mf_err", err_count, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mf_no_stale", out_valid, 0);
    end
    // random traffic
    for (int i = 0; i < 400; i++) begin
      put_rand();
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      tick();
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
